// File: rtl/bus_arbiter_if.sv
// Shared port bundle of the two-master arbiter: both master handshakes plus the decoder-side bus.
// The master modport is the arbiter's view; slave is the masters-plus-decoder environment.
interface bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;

  logic [AW-1:0] addr_bus;
  logic          m_read;
  logic          m_write;
  logic [DW-1:0] d_t_mem;
  logic [DW-1:0] d_f_mem;
  logic          grant_id;
  logic          busy;

  modport master (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  d_f_mem,
    output m0_rdata, m0_ack, m1_rdata, m1_ack,
    output addr_bus, m_read, m_write, d_t_mem, grant_id, busy
  );

  modport slave (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output d_f_mem,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack,
    input  addr_bus, m_read, m_write, d_t_mem, grant_id, busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin two-master arbiter: write acks 2 cycles after grant sampling, read acks RD_WAIT+2.
// Masters hold req until ack; one transfer in flight, every output registered.
module bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RD_WAIT = 1
) (
  input logic           clk,
  input logic           rst,
  bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

  localparam logic [2:0] RD_WAIT_C = 3'(RD_WAIT);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dtm_q, dtm_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          rd_q, rd_d, wr_q, wr_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          gid_q, gid_d, lg_q, lg_d;
  logic          we_q, we_d, busy_q, busy_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          win;

  // Both requesting: the master that did not own the last transfer wins.
  assign win = (bus.m0_req && bus.m1_req) ? ~lg_q : bus.m1_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      dtm_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      gid_q    <= 1'b0;
      lg_q     <= 1'b1;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dtm_q    <= dtm_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      gid_q    <= gid_d;
      lg_q     <= lg_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.m0_req || bus.m1_req) state_d = XFER;
      XFER:    if (we_q || cnt_q == RD_WAIT_C) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Computes the next value of every registered output from the current state and transition.
  always_comb begin
    addr_d   = '0;
    dtm_d    = '0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    gid_d    = gid_q;
    lg_d     = lg_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    busy_d   = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (state_d == XFER) begin
          gid_d  = win;
          lg_d   = win;
          we_d   = win ? bus.m1_we : bus.m0_we;
          addr_d = win ? bus.m1_addr : bus.m0_addr;
          wr_d   = we_d;
          rd_d   = ~we_d;
          dtm_d  = we_d ? (win ? bus.m1_wdata : bus.m0_wdata) : '0;
          cnt_d  = '0;
        end
      end
      XFER: begin
        if (state_d == ACK) begin
          ack0_d = ~gid_q;
          ack1_d = gid_q;
          if (!we_q) begin
            if (gid_q) rdata1_d = bus.d_f_mem;
            else       rdata0_d = bus.d_f_mem;
          end
        end else begin
          // Only reads linger in XFER; writes always leave after one cycle.
          addr_d = addr_q;
          rd_d   = 1'b1;
          cnt_d  = cnt_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  assign bus.addr_bus = addr_q;
  assign bus.m_read   = rd_q;
  assign bus.m_write  = wr_q;
  assign bus.d_t_mem  = dtm_q;
  assign bus.m0_ack   = ack0_q;
  assign bus.m1_ack   = ack1_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: RD_WAIT=1 and RD_WAIT=0 instances against a transaction-schedule model.
// Masters react at the falling edge, so a dropped req lands on the edge ending the ack cycle.
module tb_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        req[2];
  logic        we[2];
  logic [31:0] addr[2];
  logic [31:0] wdata[2];
  logic        sel;
  int          rw;

  int total, bad, cyc;

  bus_arbiter_if #(.AW(32), .DW(32)) bif1 ();
  bus_arbiter_if #(.AW(32), .DW(32)) bif0 ();

  bus_arbiter #(.AW(32), .DW(32), .RD_WAIT(1)) dut1 (.clk(clk), .rst(rst), .bus(bif1.master));
  bus_arbiter #(.AW(32), .DW(32), .RD_WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(bif0.master));

  function automatic logic [31:0] rdval(input logic [31:0] a);
    if (a == 32'hC0000004) return 32'h00000041;
    return a * 32'h9E3779B1 + 32'd1;
  endfunction

  assign bif1.m0_req = req[0];   assign bif0.m0_req = req[0];
  assign bif1.m0_we = we[0];     assign bif0.m0_we = we[0];
  assign bif1.m0_addr = addr[0]; assign bif0.m0_addr = addr[0];
  assign bif1.m0_wdata = wdata[0]; assign bif0.m0_wdata = wdata[0];
  assign bif1.m1_req = req[1];   assign bif0.m1_req = req[1];
  assign bif1.m1_we = we[1];     assign bif0.m1_we = we[1];
  assign bif1.m1_addr = addr[1]; assign bif0.m1_addr = addr[1];
  assign bif1.m1_wdata = wdata[1]; assign bif0.m1_wdata = wdata[1];
  assign bif1.d_f_mem = bif1.m_read ? rdval(bif1.addr_bus) : 32'hBAD0BAD0;
  assign bif0.d_f_mem = bif0.m_read ? rdval(bif0.addr_bus) : 32'hBAD0BAD0;

  logic [65:0] obs_bus;
  logic [1:0]  obs_ack;
  logic [63:0] obs_rdata;
  logic [1:0]  obs_ctl;
  assign obs_bus   = sel ? {bif0.addr_bus, bif0.m_read, bif0.m_write, bif0.d_t_mem}
                         : {bif1.addr_bus, bif1.m_read, bif1.m_write, bif1.d_t_mem};
  assign obs_ack   = sel ? {bif0.m1_ack, bif0.m0_ack} : {bif1.m1_ack, bif1.m0_ack};
  assign obs_rdata = sel ? {bif0.m1_rdata, bif0.m0_rdata} : {bif1.m1_rdata, bif1.m0_rdata};
  assign obs_ctl   = sel ? {bif0.grant_id, bif0.busy} : {bif1.grant_id, bif1.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model: one transfer record plus the cycle the bus is next free.
  bit          have_tr, t_w, t_we, lg, exp_gid;
  int          s_c, ack_c, free_c;
  logic [31:0] t_addr, t_wdata;
  logic [31:0] exp_rdata[2];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    have_tr = 0; free_c = 0; lg = 1; exp_gid = 0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
  endtask

  task automatic model_eval();
    if (!rst && cyc >= free_c && (req[0] || req[1])) begin
      t_w     = (req[0] && req[1]) ? !lg : req[1];
      lg      = t_w;
      have_tr = 1;
      s_c     = cyc;
      t_we    = we[t_w];
      t_addr  = addr[t_w];
      t_wdata = wdata[t_w];
      ack_c   = cyc + (t_we ? 2 : rw + 2);
      free_c  = ack_c + 1;
    end
  endtask

  task automatic check_cycle();
    logic rd, wr, bz;
    logic [31:0] a, d;
    logic [1:0] ak;
    rd = have_tr && !t_we && cyc >= s_c + 1 && cyc <= s_c + 1 + rw;
    wr = have_tr && t_we && cyc == s_c + 1;
    a  = (rd || wr) ? t_addr : '0;
    d  = wr ? t_wdata : '0;
    ak = (have_tr && cyc == ack_c) ? (t_w ? 2'b10 : 2'b01) : 2'b00;
    bz = have_tr && cyc > s_c && cyc <= ack_c;
    if (have_tr && cyc == s_c + 1) exp_gid = t_w;
    if (have_tr && !t_we && cyc == ack_c) exp_rdata[t_w] = rdval(t_addr);
    check("bus", 128'(obs_bus), 128'({a, rd, wr, d}));
    check("ack", 128'(obs_ack), 128'(ak));
    check("rdata", 128'(obs_rdata), 128'({exp_rdata[1], exp_rdata[0]}));
    check("ctl", 128'(obs_ctl), 128'({exp_gid, bz}));
  endtask

  task automatic advance();
    model_eval();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    advance();
    advance();
    rst = 1'b0;
  endtask

  task automatic drain();
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (10) advance();
  endtask

  task automatic issue(input int m, input bit w, input logic [31:0] a, input logic [31:0] d);
    req[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d;
  endtask

  task automatic wait_ack(input int m, output int ca);
    bit seen = 0;
    ca = -1;
    for (int k = 0; k < 20 && !seen; k++) begin
      advance();
      if (obs_ack[m]) begin
        seen = 1; ca = cyc; req[m] = 1'b0;
      end
    end
    check("ack_seen", 128'(seen), 128'(1));
  endtask

  task automatic masters_react();
    for (int m = 0; m < 2; m++) begin
      if (req[m]) begin
        if (obs_ack[m]) req[m] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        issue(m, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
    end
  endtask

  task automatic random_run(input int n);
    for (int k = 0; k < n; k++) begin
      masters_react();
      advance();
    end
    drain();
  endtask

  initial begin
    int c0, ca, n;
    total = 0; bad = 0; cyc = 0;
    sel = 1'b0; rw = 1; rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; we[m] = 1'b0; addr[m] = '0; wdata[m] = '0;
    end
    model_reset();
    @(negedge clk);
    do_reset();

    // Single write from master 0
    c0 = cyc;
    issue(0, 1'b1, 32'h00000010, 32'hDEADBEEF);
    wait_ack(0, ca);
    check("wr_lat", 128'(ca - c0), 128'(2));
    drain();

    // Single read from master 1
    c0 = cyc;
    issue(1, 1'b0, 32'hC0000004, 32'h0);
    wait_ack(1, ca);
    check("rd_lat", 128'(ca - c0), 128'(3));
    check("rd_data", 128'(obs_rdata[63:32]), 128'(32'h00000041));
    check("rd_other", 128'(obs_rdata[31:0]), 128'(0));
    drain();
    check("rd_held", 128'(obs_rdata[63:32]), 128'(32'h00000041));

    // Continuous contention out of reset: grants alternate starting with master 0
    do_reset();
    issue(0, 1'b0, $urandom, 32'h0);
    issue(1, 1'b0, $urandom, 32'h0);
    n = 0;
    for (int k = 0; k < 100 && n < 8; k++) begin
      advance();
      for (int m = 0; m < 2; m++) begin
        if (req[m] && obs_ack[m]) begin
          check("rr_order", 128'(obs_ctl[1]), 128'(n % 2));
          check("rr_master", 128'(m), 128'(n % 2));
          n++;
          req[m] = 1'b0;
        end else if (!req[m]) begin
          issue(m, 1'b0, $urandom, 32'h0);
        end
      end
    end
    check("rr_count", 128'(n), 128'(8));
    drain();

    // Reset in the second XFER cycle of a read, then the held request completes
    issue(0, 1'b0, 32'h00001234, 32'h0);
    advance();
    advance();
    rst = 1'b1;
    #1;
    check("rst_async", 128'({obs_bus[65:64], obs_ctl[0]}), 128'(0));
    model_reset();
    advance();
    advance();
    rst = 1'b0;
    c0 = cyc;
    wait_ack(0, ca);
    check("rst_regrant", 128'(ca - c0), 128'(3));
    check("rst_data", 128'(obs_rdata[31:0]), 128'(rdval(32'h00001234)));
    drain();

    // Master 0 drops req during XFER: exactly one ack, no follow-up transfer
    issue(0, 1'b0, 32'h00000200, 32'h0);
    advance();
    req[0] = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      advance();
      if (obs_ack[0]) n++;
    end
    check("drop_acks", 128'(n), 128'(1));
    check("drop_idle", 128'(obs_ctl[0]), 128'(0));

    random_run(300);

    // RD_WAIT=0 instance
    sel = 1'b1; rw = 0;
    do_reset();
    c0 = cyc;
    issue(0, 1'b0, 32'h00000400, 32'h0);
    wait_ack(0, ca);
    check("rw0_lat", 128'(ca - c0), 128'(2));
    check("rw0_data", 128'(obs_rdata[31:0]), 128'(rdval(32'h00000400)));
    drain();
    random_run(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
